mvm_gate_scheduler: RTL and testbench

- Shares one matrix-vector dot-product engine between NREQ gate requesters (LSTM input, forget, cell and output gates).
- Arbitrates round-robin among pending requests and latches the operand vector for the granted request.
- Sequences the engine by driving its reset, addresses the weight memory, and feeds one vector element per cycle.
- Captures the engine result on dataReady and returns it to the requester with a done pulse; a watchdog flags a stalled engine.

---
 rtl/mvm_gate_scheduler_if.sv | 18 +
 rtl/mvm_gate_scheduler.sv | 118 +++++++++++
 tb/tb_mvm_gate_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mvm_gate_scheduler_if.sv
// mvm_gate_scheduler_if: requester-side bus of the gate scheduler
interface mvm_gate_scheduler_if #(
    parameter int NREQ     = 4,
    parameter int NCOL     = 16,
    parameter int NROW     = 16,
    parameter int BITWIDTH = 18,
    parameter int ID_W     = $clog2(NREQ),
    parameter int LAYER_W  = BITWIDTH * NROW
);
    logic [NREQ-1:0]          req;
    logic [NREQ-1:0]          grant;
    logic [NREQ-1:0]          done;
    logic [NCOL*BITWIDTH-1:0] x_vec;
    logic [LAYER_W-1:0]       res_vector;
    logic [ID_W-1:0]          res_id;
    modport master (output req, x_vec, input grant, done, res_vector, res_id);
    modport slave (input req, x_vec, output grant, done, res_vector, res_id);
endinterface

// File: rtl/mvm_gate_scheduler.sv
// mvm_gate_scheduler: shares one matrix-vector engine between NREQ gate requesters
module mvm_gate_scheduler #(
    parameter int NROW          = 16,
    parameter int NCOL          = 16,
    parameter int QN            = 6,
    parameter int QM            = 11,
    parameter int DSP48_PER_ROW = 4,
    parameter int NREQ          = 4,
    parameter int TIMEOUT       = 255,
    parameter int BITWIDTH      = QN + QM + 1,
    parameter int ADDR_W        = $clog2(NCOL),
    parameter int ID_W          = $clog2(NREQ),
    parameter int LAYER_W       = BITWIDTH * NROW
) (
    input  logic                   clk,
    input  logic                   reset,
    mvm_gate_scheduler_if.slave    bus,
    output logic                   busy,
    output logic                   err_timeout,
    output logic                   eng_reset,
    input  logic [ADDR_W-1:0]      eng_colAddress,
    input  logic                   eng_dataReady,
    input  logic [LAYER_W-1:0]     eng_outputVector,
    output logic [BITWIDTH-1:0]    eng_inputVector,
    output logic [ID_W+ADDR_W-1:0] w_addr
);
    localparam int RUN_CYCLES = NCOL * DSP48_PER_ROW;
    localparam int WD_MAX     = (TIMEOUT > RUN_CYCLES) ? TIMEOUT : RUN_CYCLES;
    localparam int WD_W       = $clog2(WD_MAX + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                   state, state_n;
    logic [ID_W-1:0]          ptr, id, pick, cand, next_id;
    logic                     found, wd_last;
    logic [WD_W-1:0]          wd;
    logic [NCOL*BITWIDTH-1:0] latched_vec;

    // first pending requester at or above the round-robin pointer, wrapping
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        cand  = ptr;
        for (int k = 0; k < NREQ; k++) begin
            cand = ID_W'((int'(ptr) + k) % NREQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign next_id = ID_W'((int'(id) + 1) % NREQ);
    assign wd_last = (wd == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = found ? RUN : IDLE;
            RUN:     state_n = eng_dataReady ? DONE : (wd_last ? IDLE : RUN);
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.grant      <= '0;
            bus.done       <= '0;
            bus.res_vector <= '0;
            bus.res_id     <= '0;
            err_timeout    <= 1'b0;
            eng_reset      <= 1'b1;
            ptr            <= '0;
            id             <= '0;
            latched_vec    <= '0;
            wd             <= '0;
        end else begin
            bus.done <= '0;
            case (state)
                IDLE: if (found) begin
                    bus.grant   <= NREQ'(1) << pick;
                    id          <= pick;
                    latched_vec <= bus.x_vec;
                    eng_reset   <= 1'b0;
                    wd          <= '0;
                end
                RUN: begin
                    wd <= wd + 1'b1;
                    // a result arriving on the last watchdog cycle still wins
                    if (eng_dataReady) begin
                        bus.res_vector <= eng_outputVector;
                        bus.res_id     <= id;
                        bus.done       <= NREQ'(1) << id;
                        eng_reset      <= 1'b1;
                        ptr            <= next_id;
                    end else if (wd_last) begin
                        err_timeout <= 1'b1;
                        eng_reset   <= 1'b1;
                        bus.grant   <= '0;
                        ptr         <= next_id;
                    end
                end
                DONE: bus.grant <= '0;
                default: ;
            endcase
        end
    end

    assign busy            = (state != IDLE);
    assign eng_inputVector = latched_vec[int'(eng_colAddress) * BITWIDTH +: BITWIDTH];
    assign w_addr          = {id, eng_colAddress};
endmodule

// File: tb/tb_mvm_gate_scheduler.sv
// tb_mvm_gate_scheduler: directed, table-driven and randomized checks of the gate scheduler
module tb_mvm_gate_scheduler;
    localparam int NROW = 16, NCOL = 16, BW = 18, NREQ = 4, QM = 11;
    localparam int LW = BW * NROW, XW = BW * NCOL, TO = 255, LAT = 66;

    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;

    mvm_gate_scheduler_if bus();
    logic          busy, err_timeout, eng_reset, eng_dataReady;
    logic [3:0]    eng_colAddress;
    logic [LW-1:0] eng_outputVector;
    logic [BW-1:0] eng_inputVector;
    logic [5:0]    w_addr;

    mvm_gate_scheduler dut (
        .clk(clk), .reset(reset), .bus(bus), .busy(busy), .err_timeout(err_timeout),
        .eng_reset(eng_reset), .eng_colAddress(eng_colAddress), .eng_dataReady(eng_dataReady),
        .eng_outputVector(eng_outputVector), .eng_inputVector(eng_inputVector), .w_addr(w_addr)
    );

    int errors = 0, checks = 0;
    logic [BW-1:0] wmem [64][NROW];

    function automatic int prod(input logic [BW-1:0] a, input logic [BW-1:0] b);
        return int'((longint'($signed(a)) * longint'($signed(b))) >>> QM);
    endfunction

    // engine: 4 passes over the columns, each pass accumulating 4 rows
    logic [6:0] ecnt = '0;
    logic       stall = 1'b0;
    int         acc [NROW];
    assign eng_colAddress = ecnt[3:0];
    assign eng_dataReady  = (ecnt == 7'd65) && !stall;
    always_comb for (int r = 0; r < NROW; r++) eng_outputVector[r*BW +: BW] = acc[r][BW-1:0];
    always @(posedge clk) begin
        if (eng_reset) begin
            ecnt <= '0;
            for (int r = 0; r < NROW; r++) acc[r] <= 0;
        end else if (ecnt < 7'd65) begin
            ecnt <= ecnt + 1'b1;
            if (ecnt < 7'd64)
                for (int j = 0; j < 4; j++)
                    acc[int'(ecnt[5:4])*4+j] <= acc[int'(ecnt[5:4])*4+j]
                        + prod(eng_inputVector, wmem[w_addr][int'(ecnt[5:4])*4+j]);
        end
    end

    // reference result: plain fixed-point matrix-vector product
    function automatic logic [LW-1:0] mvm(input logic [XW-1:0] xv, input int id);
        logic [LW-1:0] o;
        int s;
        o = '0;
        for (int r = 0; r < NROW; r++) begin
            s = 0;
            for (int k = 0; k < NCOL; k++) s += prod(xv[k*BW +: BW], wmem[id*NCOL+k][r]);
            o[r*BW +: BW] = s[BW-1:0];
        end
        return o;
    endfunction

    function automatic logic [3:0] oh(input int i);
        return 4'(1) << i;
    endfunction

    function automatic logic [BW-1:0] rand_fix();
        return BW'($urandom_range(4095)) - BW'(2048);
    endfunction

    function automatic logic [XW-1:0] rand_vec();
        logic [XW-1:0] v;
        for (int k = 0; k < NCOL; k++) v[k*BW +: BW] = rand_fix();
        return v;
    endfunction

    function automatic logic [XW-1:0] half_vec();
        logic [XW-1:0] v;
        for (int k = 0; k < NCOL; k++) v[k*BW +: BW] = 18'h00400;
        return v;
    endfunction

    task automatic set_w(input logic rnd);
        for (int a = 0; a < 64; a++)
            for (int r = 0; r < NROW; r++) wmem[a][r] = rnd ? rand_fix() : 18'h00400;
    endtask

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req = '0;
        stall = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_grant(input int lim, output int n);
        n = 0;
        while (bus.grant == '0 && n < lim) begin step(); n++; end
        if (bus.grant == '0) begin
            checks++; errors++;
            $display("FAIL grant_wait: no grant within %0d cycles", lim);
        end
    endtask

    task automatic wait_done(input int lim, output int n);
        n = 0;
        while (bus.done == '0 && n < lim) begin step(); n++; end
        if (bus.done == '0) begin
            checks++; errors++;
            $display("FAIL done_wait: no done within %0d cycles", lim);
        end
    endtask

    task automatic run(input logic [3:0] r, input logic [3:0] expg, input string nm);
        int n, id;
        logic [XW-1:0] xl;
        id = 0;
        for (int i = 0; i < NREQ; i++) if (expg[i]) id = i;
        bus.req = r;
        wait_grant(8, n);
        xl = bus.x_vec;
        chk({nm, "_grant"}, LW'(bus.grant), LW'(expg));
        wait_done(TO + 10, n);
        chk({nm, "_done"}, LW'(bus.done), LW'(expg));
        chk({nm, "_latency"}, LW'(n), LW'(LAT));
        chk({nm, "_res"}, bus.res_vector, mvm(xl, id));
        chk({nm, "_res_id"}, LW'(bus.res_id), LW'(id));
        bus.req = '0;
        step();
    endtask

    // cycle-numbered job model: a job granted at edge st reports at st+66 and frees the engine at st+67
    task automatic random_phase();
        int cur, st, p, pk;
        logic [3:0] rq, g, d;
        logic [XW-1:0] xv;
        logic [LW-1:0] exp_res;
        cur = -1; st = 0; p = 0; rq = '0; exp_res = '0;
        for (int e = 1; e <= 4000; e++) begin
            xv = rand_vec();
            bus.x_vec = xv;
            for (int i = 0; i < NREQ; i++) if (!rq[i] && $urandom_range(99) < 3) rq[i] = 1'b1;
            bus.req = rq;
            step();
            if (cur >= 0 && e == st + 67) cur = -1;
            else if (cur < 0 && rq != '0) begin
                pk = -1;
                for (int k = 0; k < NREQ; k++) if (pk < 0 && rq[(p+k)%NREQ]) pk = (p + k) % NREQ;
                cur = pk;
                st = e;
                exp_res = mvm(xv, cur);
            end
            g = (cur >= 0) ? oh(cur) : 4'b0;
            d = (cur >= 0 && e == st + 66) ? oh(cur) : 4'b0;
            chk("rnd_ctl", LW'({bus.grant, bus.done, busy, eng_reset}),
                LW'({g, d, cur >= 0, !(cur >= 0 && e < st + 66)}));
            if (d != '0) begin
                chk("rnd_res", bus.res_vector, exp_res);
                chk("rnd_res_id", LW'(bus.res_id), LW'(cur));
                p = (cur + 1) % NREQ;
                rq[cur] = 1'($urandom_range(1));
            end
        end
        bus.req = '0;
    endtask

    typedef struct {
        int         prev;
        logic [3:0] rq;
        logic [3:0] exp;
    } arb_t;
    arb_t tbl [6];

    initial begin
        int n, bad, dones;
        logic [XW-1:0] xv;
        logic [LW-1:0] quarter16;
        tbl[0] = '{0, 4'b1111, 4'b0010};
        tbl[1] = '{1, 4'b0011, 4'b0001};
        tbl[2] = '{3, 4'b1000, 4'b1000};
        tbl[3] = '{2, 4'b0110, 4'b0010};
        tbl[4] = '{2, 4'b1001, 4'b1000};
        tbl[5] = '{0, 4'b0001, 4'b0001};
        for (int r = 0; r < NROW; r++) quarter16[r*BW +: BW] = 18'h02000;
        bus.req = '0;
        bus.x_vec = '0;
        set_w(1'b0);
        do_reset();
        chk("rst_grant", LW'(bus.grant), 0);
        chk("rst_done", LW'(bus.done), 0);
        chk("rst_res", bus.res_vector, 0);
        chk("rst_res_id", LW'(bus.res_id), 0);
        chk("rst_busy", LW'(busy), 0);
        chk("rst_err", LW'(err_timeout), 0);
        chk("rst_eng_reset", LW'(eng_reset), 1);

        // single request with 0.5 operands and weights
        bus.x_vec = half_vec();
        bus.req = 4'b0010;
        wait_grant(8, n);
        chk("single_grant", LW'(bus.grant), LW'(4'b0010));
        chk("single_eng_reset", LW'(eng_reset), 0);
        wait_done(100, n);
        chk("single_latency", LW'(n), LW'(LAT));
        chk("single_done", LW'(bus.done), LW'(4'b0010));
        chk("single_res", bus.res_vector, quarter16);
        chk("single_res_id", LW'(bus.res_id), 1);
        chk("single_busy_done", LW'(busy), 1);
        bus.req = '0;
        step();
        chk("single_pulse", LW'({bus.done, bus.grant, busy}), 0);

        // arbitration table: a preceding job sets the pointer to prev+1
        set_w(1'b1);
        bus.x_vec = rand_vec();
        for (int t = 0; t < 6; t++) begin
            run(oh(tbl[t].prev), oh(tbl[t].prev), "arb_pre");
            run(tbl[t].rq, tbl[t].exp, "arb");
        end

        // operand stability and weight addressing
        do_reset();
        xv = rand_vec();
        bus.x_vec = xv;
        bus.req = 4'b1000;
        wait_grant(8, n);
        bad = 0;
        for (int c = 0; c < 64; c++) begin
            if (c == 10) bus.x_vec = rand_vec();
            if (w_addr !== {2'd3, 4'(c % 16)}) bad++;
            step();
        end
        chk("waddr_track", LW'(bad), 0);
        wait_done(10, n);
        chk("stable_latency", LW'(n + 64), LW'(LAT));
        chk("stable_res", bus.res_vector, mvm(xv, 3));
        bus.req = '0;
        step();

        // reset in the middle of a run
        do_reset();
        bus.x_vec = rand_vec();
        bus.req = 4'b0001;
        wait_grant(8, n);
        repeat (30) step();
        reset = 1'b1;
        step();
        chk("midrst_state", LW'({bus.grant, bus.done, busy, eng_reset}), LW'(9'b0000_0000_1));
        reset = 1'b0;
        run(4'b0001, 4'b0001, "post_reset");

        // request withdrawn during the run
        do_reset();
        bus.req = 4'b0100;
        wait_grant(8, n);
        repeat (5) step();
        bus.req = '0;
        wait_done(100, n);
        chk("withdraw_done", LW'(bus.done), LW'(4'b0100));
        chk("withdraw_latency", LW'(n + 5), LW'(LAT));
        bad = 0;
        repeat (10) begin step(); if (bus.grant != '0) bad++; end
        chk("withdraw_no_regrant", LW'(bad), 0);

        // all four requesting: rotation and inter-run gap
        do_reset();
        bus.req = 4'b1111;
        dones = 0;
        wait_grant(8, n);
        for (int j = 0; j < 5; j++) begin
            chk("rot_grant", LW'(bus.grant), LW'(oh(j % 4)));
            wait_done(100, n);
            chk("rot_latency", LW'(n), LW'(LAT));
            if (bus.done == bus.grant) dones++;
            if (j == 3) chk("rot_dones", LW'(dones), 4);
            chk("rot_gap0_eng_reset", LW'(eng_reset), 1);
            step();
            chk("rot_gap1", LW'({bus.grant, eng_reset}), LW'(5'b0000_1));
            step();
        end
        bus.req = '0;
        step();
        step();

        // stalled engine trips the watchdog, then a pending request is served
        do_reset();
        stall = 1'b1;
        bus.req = 4'b0001;
        wait_grant(8, n);
        repeat (TO - 1) step();
        chk("to_before", LW'({err_timeout, bus.grant}), LW'(5'b0_0001));
        bus.req = 4'b0100;
        step();
        chk("to_err", LW'(err_timeout), 1);
        chk("to_state", LW'({bus.grant, bus.done, eng_reset}), LW'(9'b0000_0000_1));
        stall = 1'b0;
        run(4'b0100, 4'b0100, "after_to");
        chk("to_sticky", LW'(err_timeout), 1);

        do_reset();
        random_phase();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "global timeout");
    end
endmodule
